// File: rtl/regfile_wb_queue.sv
// Writeback queue between the MEM/ALU result sources and the register file write port.
// Optional macro REGFILE_WB_X0_DROP_EN: accepted writes to x0 are acknowledged but not stored.
module regfile_wb_queue #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [4:0]               mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  output logic                     reg_write,
  output logic [4:0]               waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [4:0]               query_addr,
  output logic                     query_pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [4:0]        addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              mem_fire, alu_fire, push, store, pop;
  logic [4:0]        push_addr;
  logic [DATA_W-1:0] push_data;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

  // Readies depend only on registered occupancy and mem_valid, never on alu_valid.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign push      = mem_fire || alu_fire;
  assign push_addr = mem_fire ? mem_addr : alu_addr;
  assign push_data = mem_fire ? mem_data : alu_data;

`ifdef REGFILE_WB_X0_DROP_EN
  assign store = push && (push_addr != 5'd0);
`else
  assign store = push;
`endif

  // The register file never stalls, so any occupied head retires every cycle.
  assign pop = !empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop);
      tail_q  <= tail_q + PTR_W'(store);
      count_q <= count_q + CNT_W'(store) - CNT_W'(pop);
    end
  end

  // NOTE: entry storage has no reset; occupancy alone decides whether an entry is visible.
  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[tail_q] <= push_addr;
      data_mem[tail_q] <= push_data;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    reg_write = 1'b0;
    waddr     = '0;
    wdata     = '0;
    if (!empty) begin
      reg_write = 1'b1;
      waddr     = addr_mem[head_q];
      wdata     = data_mem[head_q];
    end
  end

  // A slot is occupied when its distance from head (mod DEPTH) is below the count.
  always_comb begin
    query_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q) &&
          (addr_mem[i] == query_addr) && (query_addr != 5'd0)) begin
        query_pending = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus random traffic
// compared each cycle against an in-order queue model of accepted writes.
module tb_regfile_wb_queue;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk, arst_n;
  logic              mem_valid, alu_valid, mem_ready, alu_ready;
  logic [4:0]        mem_addr, alu_addr, waddr, query_addr;
  logic [DATA_W-1:0] mem_data, alu_data, wdata;
  logic              reg_write, query_pending, full, empty;
  logic [CW-1:0]     count;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t model_q[$];
  logic acc_pending;
  ent_t acc_ent;

  regfile_wb_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst_n(arst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
    .query_addr(query_addr), .query_pending(query_pending),
    .count(count), .full(full), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against what the queue model says must be visible now.
  task automatic check_all(input string tag);
    logic exp_full, exp_qp;
    exp_full = (model_q.size() == DEPTH);
    exp_qp   = 1'b0;
    foreach (model_q[i])
      if (query_addr != 5'd0 && model_q[i].addr == query_addr) exp_qp = 1'b1;
    check({tag, ".reg_write"}, 32'(reg_write), 32'(model_q.size() != 0));
    check({tag, ".waddr"},     32'(waddr),     model_q.size() != 0 ? 32'(model_q[0].addr) : 32'd0);
    check({tag, ".wdata"},     32'(wdata),     model_q.size() != 0 ? 32'(model_q[0].data) : 32'd0);
    check({tag, ".count"},     32'(count),     32'(model_q.size()));
    check({tag, ".full"},      32'(full),      32'(exp_full));
    check({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
    check({tag, ".mem_ready"}, 32'(mem_ready), 32'(!exp_full));
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(!exp_full && !mem_valid));
    check({tag, ".query"},     32'(query_pending), 32'(exp_qp));
  endtask

  // One clock: check mid-cycle, decide acceptance from the model, then retire/append after the edge.
  task automatic cycle(input string tag);
    logic room;
    @(negedge clk);
    check_all(tag);
    room        = (model_q.size() < DEPTH);
    acc_pending = 1'b0;
    if (mem_valid && room) begin
      acc_pending = 1'b1;
      acc_ent     = '{addr: mem_addr, data: mem_data};
    end else if (alu_valid && room) begin
      acc_pending = 1'b1;
      acc_ent     = '{addr: alu_addr, data: alu_data};
    end
`ifdef REGFILE_WB_X0_DROP_EN
    if (acc_ent.addr == 5'd0) acc_pending = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (model_q.size() != 0) void'(model_q.pop_front());
    if (acc_pending) model_q.push_back(acc_ent);
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; alu_valid = 1'b0;
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0;
  endtask

  initial begin
    arst_n = 1'b0;
    query_addr = '0;
    idle_inputs();

    // Reset state, including alu_ready following mem_valid while held in reset.
    #12;
    check_all("reset");
    mem_valid = 1'b1;
    #1;
    check("reset.alu_ready_memv", 32'(alu_ready), 32'd0);
    check("reset.mem_ready_memv", 32'(mem_ready), 32'd1);
    mem_valid = 1'b0;
    @(posedge clk);
    #1 arst_n = 1'b1;

    // Single MEM write appears the next cycle, then the queue drains.
    mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 16'h1234;
    cycle("mem1");
    idle_inputs();
    check("mem1.reg_write", 32'(reg_write), 32'd1);
    check("mem1.waddr",     32'(waddr),     32'd5);
    check("mem1.wdata",     32'(wdata),     32'h1234);
    cycle("mem1_issue");
    cycle("mem1_drained");
    check("mem1.empty_after", 32'(empty), 32'd1);

    // MEM beats ALU; ALU keeps requesting and goes in next.
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 16'hBBBB;
    cycle("prio");
    mem_valid = 1'b0;
    check("prio.first_waddr", 32'(waddr), 32'd3);
    cycle("prio_alu");
    alu_valid = 1'b0;
    check("prio.second_waddr", 32'(waddr), 32'd4);
    check("prio.second_wdata", 32'(wdata), 32'hBBBB);
    cycle("prio_drain");

    // Continuous ALU stream: one write per cycle, occupancy never above one.
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(i + 1); alu_data = 16'(16'h100 + i);
      cycle("stream");
      check("stream.count_le1", 32'(count <= CW'(1)), 32'd1);
      check("stream.not_full",  32'(full), 32'd0);
    end
    idle_inputs();
    cycle("stream_tail");

    // Pending-write query on a queued address.
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 16'h0777;
    cycle("q7_push");
    idle_inputs();
    query_addr = 5'd7;
    #1 check("query.hit7", 32'(query_pending), 32'd1);
    query_addr = 5'd0;
    #1 check("query.zero", 32'(query_pending), 32'd0);
    query_addr = 5'd7;
    cycle("q7_issue");
    check("query.drained", 32'(query_pending), 32'd0);
    cycle("q7_after");

    // x0 write: stored and issued by default, dropped when the drop option is built in.
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 16'hDEAD;
    cycle("x0_push");
    idle_inputs();
`ifdef REGFILE_WB_X0_DROP_EN
    check("x0.no_write", 32'(reg_write), 32'd0);
    check("x0.count",    32'(count),     32'd0);
`else
    check("x0.write", 32'(reg_write), 32'd1);
    check("x0.waddr", 32'(waddr),     32'd0);
`endif
    cycle("x0_issue");

    // Reset pulsed with an entry queued: write port clears immediately.
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 16'h0999;
    cycle("rst_push");
    idle_inputs();
    #2 arst_n = 1'b0;
    #1;
    check("midrst.reg_write", 32'(reg_write), 32'd0);
    check("midrst.count",     32'(count),     32'd0);
    check("midrst.empty",     32'(empty),     32'd1);
    model_q.delete();
    #1 arst_n = 1'b1;
    cycle("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      mem_valid  = ($urandom_range(0, 3) == 0);
      alu_valid  = ($urandom_range(0, 1) == 1);
      mem_addr   = 5'($urandom_range(0, 7));
      alu_addr   = 5'($urandom_range(0, 7));
      mem_data   = 16'($urandom);
      alu_data   = 16'($urandom);
      query_addr = 5'($urandom_range(0, 7));
      cycle("rand");
    end
    idle_inputs();
    cycle("final_drain");
    cycle("final_idle");
    check("final.empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
